// File: rtl/regfile_dump_pkg.sv
// Shared constants and FSM encoding for the register-file debug dump path.
// Default sizes match the 32x32 register file they are reused with.
package regfile_dump_pkg;

  localparam int unsigned REGFILE_NUM_REGS = 32;
  localparam int unsigned REGFILE_ADDR_W   = 5;
  localparam int unsigned REGFILE_DATA_W   = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    DONE = 3'd3,
    CSUM = 3'd4
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Debug reader: walks regfile read port B from 0 to NUM_REGS-1 and streams words out.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module regfile_dump_ctrl
  import regfile_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = REGFILE_NUM_REGS,
  parameter int unsigned ADDR_W   = REGFILE_ADDR_W,
  parameter int unsigned DATA_W   = REGFILE_DATA_W
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   out_index,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state;
  logic [ADDR_W-1:0] idx;
  logic              handshake;
  logic              at_last;

  assign handshake = out_valid && out_ready;
  assign at_last   = (idx == LAST_IDX);
  assign rd_addr   = idx;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= LOAD;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end
        LOAD: begin
          out_data  <= rd_data;
          out_index <= {1'b0, idx};
`ifdef REGFILE_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
`else
          out_last  <= at_last;
`endif
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (handshake) begin
            out_valid <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum      <= csum ^ out_data;
`endif
            if (at_last) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              state <= CSUM;
`else
              state <= DONE;
              done  <= 1'b1;
`endif
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= LOAD;
            end
          end
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        // First CSUM cycle loads the checksum word, later cycles hold it until accepted.
        CSUM: begin
          if (!out_valid) begin
            out_data  <= csum;
            out_index <= (ADDR_W + 1)'(NUM_REGS);
            out_last  <= 1'b1;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= DONE;
            done      <= 1'b1;
          end
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: bench-owned register file model, random ready,
// expected dumps queued at start and compared by an independent monitor.
module tb_regfile_dump_ctrl;
  import regfile_dump_pkg::*;

  localparam int unsigned NR = REGFILE_NUM_REGS;
  localparam int unsigned AW = REGFILE_ADDR_W;
  localparam int unsigned DW = REGFILE_DATA_W;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int unsigned EXP_S2D = 2 * NR + 2;
`else
  localparam int unsigned EXP_S2D = 2 * NR;
`endif

  logic          clock = 1'b0;
  logic          ctrl_reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   out_index;
  logic          out_last;

  logic [DW-1:0] regs [NR];

  typedef struct packed {
    logic [AW:0]   idx;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  word_t       sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned done_cnt = 0;
  int unsigned hs_cnt   = 0;
  int unsigned last_done_cyc = 0;
  int unsigned first_valid_cyc = 0;
  bit          seen_first = 1'b0;
  bit          ready_rand = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign rd_data = regs[rd_addr];

  regfile_dump_ctrl #(
    .NUM_REGS(NR),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting, got no event expected one", name);
  endtask

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  // Expected dump from the current register contents; the last data word (or the checksum) ends it.
  task automatic push_dump();
    word_t         w;
    logic [DW-1:0] x;
    x = '0;
    for (int k = 0; k < int'(NR); k++) begin
      w.idx  = (AW + 1)'(k);
      w.data = regs[k];
`ifdef REGFILE_DUMP_CHECKSUM_EN
      w.last = 1'b0;
`else
      w.last = (k == int'(NR) - 1);
`endif
      x = x ^ regs[k];
      sb.push_back(w);
    end
`ifdef REGFILE_DUMP_CHECKSUM_EN
    w.idx  = (AW + 1)'(NR);
    w.data = x;
    w.last = 1'b1;
    sb.push_back(w);
`endif
  endtask

  // Registers not yet loaded will be read with their new value.
  task automatic write_reg(input int unsigned r, input logic [DW-1:0] v);
    word_t         w;
    logic [DW-1:0] delta;
    delta = '0;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].idx == (AW + 1)'(r)) begin
        w = sb[i];
        delta = w.data ^ v;
        w.data = v;
        sb[i] = w;
      end
    end
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].idx == (AW + 1)'(NR)) begin
        w = sb[i];
        w.data = w.data ^ delta;
        sb[i] = w;
      end
    end
    regs[r] = v;
  endtask

  task automatic do_start(output int unsigned s);
    seen_first = 1'b0;
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int unsigned d0, input int unsigned budget, input string name);
    int unsigned n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) fail_timeout(name);
  endtask

  task automatic wait_index(input int unsigned i, input int unsigned budget, input string name);
    int unsigned n;
    n = 0;
    while (!(out_valid && out_index == (AW + 1)'(i)) && n < budget) begin
      tick();
      n++;
    end
    if (!(out_valid && out_index == (AW + 1)'(i))) fail_timeout(name);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1 out_ready = ready_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Monitor: handshake pops the scoreboard, stalls must hold the word, done follows the last word.
  initial begin
    word_t e;
    word_t pw;
    logic  pv;
    logic  pr;
    logic  exp_done;
    pv = 1'b0;
    pr = 1'b0;
    pw = '0;
    exp_done = 1'b0;
    forever begin
      @(negedge clock);
      if (ctrl_reset) begin
        pv = 1'b0;
        exp_done = 1'b0;
      end else begin
        check("done_pulse", done, exp_done);
        if (done) begin
          done_cnt++;
          last_done_cyc = cyc;
        end
        exp_done = 1'b0;
        if (pv && !pr) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_word", {out_index, out_data, out_last}, pw);
        end
        if (out_valid) begin
          check("busy_while_valid", busy, 1'b1);
          if (!seen_first) begin
            seen_first = 1'b1;
            first_valid_cyc = cyc;
          end
          if (out_ready) begin
            if (sb.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_word: got index %0d, expected no word", out_index);
            end else begin
              e = sb.pop_front();
              check("word_index", out_index, e.idx);
              check("word_data", out_data, e.data);
              check("word_last", out_last, e.last);
              exp_done = e.last;
              hs_cnt++;
            end
          end
        end
        pv = out_valid;
        pr = out_ready;
        pw = {out_index, out_data, out_last};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned s_cyc;
    int unsigned d_cyc;
    int unsigned d0;
    int unsigned h0;
    int unsigned n;
    ctrl_reset = 1'b1;
    start = 1'b0;
    for (int k = 0; k < int'(NR); k++) regs[k] = DW'(k) * 32'h0101_0101;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_rd_addr", rd_addr, '0);
    check("rst_data", out_data, '0);
    check("rst_index", out_index, '0);
    check("rst_last", out_last, 1'b0);
    @(posedge clock);
    #2 ctrl_reset = 1'b0;

    // Full-speed dump of the k*0x01010101 pattern.
    d0 = done_cnt;
    push_dump();
    do_start(s_cyc);
    wait_done(d0, 200, "t1_done");
    check("start_to_done", last_done_cyc - s_cyc, EXP_S2D);
    check("first_valid_lat", first_valid_cyc - s_cyc, 1);
    check("t1_all_words", sb.size(), 0);
    repeat (8) tick();
    check("t1_single_done", done_cnt - d0, 1);
    check("t1_busy_idle", busy, 1'b0);

    // Random contents with a 30% ready duty.
    for (int k = 1; k < int'(NR); k++) regs[k] = $urandom;
    regs[0] = '0;
    ready_rand = 1'b1;
    d0 = done_cnt;
    push_dump();
    do_start(s_cyc);
    wait_done(d0, 2000, "t2_done");
    ready_rand = 1'b0;
    check("t2_all_words", sb.size(), 0);

    // Second start during word 10 must be ignored.
    d0 = done_cnt;
    h0 = hs_cnt;
    push_dump();
    do_start(s_cyc);
    n = 0;
    while (hs_cnt - h0 < 10 && n < 100) begin
      tick();
      n++;
    end
    if (hs_cnt - h0 < 10) fail_timeout("t3_word10");
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(d0, 200, "t3_done");
    repeat (8) tick();
    check("t3_single_done", done_cnt - d0, 1);
    check("t3_word_count", hs_cnt - h0, NR + (EXP_S2D - 2 * NR) / 2);
    check("t3_all_words", sb.size(), 0);

    // start held high: back-to-back dumps through IDLE after DONE.
    d0 = done_cnt;
    push_dump();
    seen_first = 1'b0;
    @(posedge clock);
    #1 start = 1'b1;
    wait_done(d0, 200, "t4_done_a");
    d_cyc = last_done_cyc;
    push_dump();
    seen_first = 1'b0;
    n = 0;
    while (!seen_first && n < 10) begin
      tick();
      n++;
    end
    if (!seen_first) fail_timeout("t4_restart");
    start = 1'b0;
    check("restart_lat", first_valid_cyc - d_cyc, 3);
    d0 = done_cnt;
    wait_done(d0, 200, "t4_done_b");
    check("t4_all_words", sb.size(), 0);
    repeat (4) tick();

    // Asynchronous reset while index 17 is presented.
    push_dump();
    do_start(s_cyc);
    wait_index(17, 100, "t5_idx17");
    #1 ctrl_reset = 1'b1;
    #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_index", out_index, '0);
    check("abort_rd_addr", rd_addr, '0);
    sb.delete();
    @(posedge clock);
    #2 ctrl_reset = 1'b0;
    d0 = done_cnt;
    repeat (6) tick();
    check("abort_no_done", done_cnt - d0, 0);
    push_dump();
    do_start(s_cyc);
    wait_done(d0, 200, "t5_done");
    check("t5_all_words", sb.size(), 0);

    // Mid-dump writes to r5: before its load (new value) and after it (old value).
    for (int k = 0; k < int'(NR); k++) regs[k] = DW'(k) * 32'h0101_0101;
    d0 = done_cnt;
    push_dump();
    do_start(s_cyc);
    wait_index(3, 50, "t6_idx3");
    write_reg(5, 32'hDEAD_BEEF);
    wait_done(d0, 200, "t6_done_a");
    check("t6a_all_words", sb.size(), 0);
    repeat (2) tick();
    d0 = done_cnt;
    push_dump();
    do_start(s_cyc);
    wait_index(7, 50, "t6_idx7");
    write_reg(5, 32'h1234_5678);
    wait_done(d0, 200, "t6_done_b");
    check("t6b_all_words", sb.size(), 0);
    repeat (2) tick();

`ifdef REGFILE_DUMP_CHECKSUM_EN
    // r_k = k: XOR of 0..31 is zero.
    for (int k = 0; k < int'(NR); k++) regs[k] = DW'(k);
    d0 = done_cnt;
    push_dump();
    do_start(s_cyc);
    wait_done(d0, 200, "t7_done");
    check("t7_all_words", sb.size(), 0);
`endif

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
